// File: rtl/spi_pwm_master.sv
// SPI mode-0 master: sends one FRAME_BITS frame MSB first per accepted start and
// captures the reply on miso. sclk comes from a clock-enable divider in the clk domain.
module spi_pwm_master #(
    parameter int unsigned FRAME_BITS = 32,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  sclk,
    output logic                  ss_n,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [FRAME_BITS-1:0]   tx_sh_q, tx_sh_d;
    logic [FRAME_BITS-1:0]   rx_sh_q, rx_sh_d;
    logic [FRAME_BITS-1:0]   rx_data_q, rx_data_d;
    logic                    mosi_q, mosi_d;
    logic                    done_q, done_d;

    logic div_last;
    logic gap_last;
    logic last_bit;

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
    assign gap_last = (div_q == DIV_W'(CLK_DIV - 2));
    assign last_bit = (bit_q == BIT_W'(FRAME_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    tx_sh_d = tx_data;
                    mosi_d  = tx_data[FRAME_BITS-1];
                    div_d   = '0;
                    bit_d   = '0;
                    rx_sh_d = '0;
                end
            end
            S_SETUP, S_LOW: begin
                if (div_last) begin
                    div_d = '0;
                    if (state_q == S_LOW) begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                    if (state_q == S_LOW && last_bit) begin
                        state_d   = S_GAP;
                        done_d    = 1'b1;
                        rx_data_d = rx_sh_q;
                    end else begin
                        state_d = S_HIGH;
                        rx_sh_d = {rx_sh_q[FRAME_BITS-2:0], miso};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_HIGH: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = S_LOW;
                    // zeros shift in behind the data, so the bit after the last one is 0
                    tx_sh_d = tx_sh_q << 1;
                    mosi_d  = tx_sh_q[FRAME_BITS-2];
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_GAP: begin
                // D-1 gap cycles plus the idle accept cycle keep ss_n high for D cycles
                if (gap_last) begin
                    div_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready   = (state_q == S_IDLE);
        busy    = (state_q != S_IDLE);
        sclk    = (state_q == S_HIGH);
        ss_n    = !((state_q == S_SETUP) || (state_q == S_HIGH) || (state_q == S_LOW));
        mosi    = mosi_q;
        done    = done_q;
        rx_data = rx_data_q;
    end

endmodule

// File: tb/tb_spi_pwm_master.sv
// Directed bench for spi_pwm_master: a cycle-position model of the frame checks
// every output each cycle; literal checks pin frame length, data and timing.
module tb_spi_pwm_master;

    localparam int N      = 32;
    localparam int D      = 4;
    localparam int LOWEND = (2 * N + 1) * D;
    localparam int PERIOD = (2 * N + 2) * D;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  tx_data;
    logic          ready, busy, done, sclk, ss_n, mosi, miso;
    logic [N-1:0]  rx_data;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    spi_pwm_master #(.FRAME_BITS(N), .CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .ready(ready), .busy(busy), .done(done), .rx_data(rx_data),
        .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // model: frame position t counted in clk cycles from the accepting edge
    bit           m_init = 0;
    bit           m_act  = 0;
    int           t      = 0;
    logic [N-1:0] m_tx = '0, m_sh = '0, m_rx = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1; m_act = 0; m_rx = '0; m_sh = '0;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1; t = 0; m_tx = tx_data;
            end
        end else begin
            t++;
            if (t >= D && t < LOWEND && ((t - D) % (2 * D)) == 0)
                m_sh = {m_sh[N-2:0], miso};
            if (t == LOWEND) m_rx = m_sh;
            if (t == PERIOD - 1) m_act = 0;
        end
    end

    // monitor statistics (updated after the per-cycle compare)
    logic         prev_sclk = 0, prev_ss = 1;
    logic [N-1:0] recon = '0, recon_at_done = '0;
    int rises = 0, rises_at_done = 0, lowrun = 0, lowrun_at_done = 0;
    int highrun = 0, last_high = 0, falls = 0, done_cnt = 0;
    int last_done_cyc = 0, prev_done_cyc = 0;

    always @(negedge clk) begin
        if (m_init) begin
            logic e_ss, e_sclk, e_mosi, e_ready, e_done;
            e_ss = 1; e_sclk = 0; e_mosi = 0; e_ready = 1; e_done = 0;
            if (m_act) begin
                e_ready = 0;
                e_done  = (t == LOWEND);
                e_ss    = (t >= LOWEND);
                if (t < D) begin
                    e_mosi = m_tx[N-1];
                end else if (t < LOWEND) begin
                    int p, k;
                    p = t - D;
                    k = p / (2 * D);
                    e_sclk = ((p % (2 * D)) < D);
                    if (e_sclk) e_mosi = m_tx[N-1-k];
                    else if (k == N - 1) e_mosi = 1'b0;
                    else e_mosi = m_tx[N-2-k];
                end
            end
            chk("ss_n",    {31'b0, ss_n},  {31'b0, e_ss});
            chk("sclk",    {31'b0, sclk},  {31'b0, e_sclk});
            chk("mosi",    {31'b0, mosi},  {31'b0, e_mosi});
            chk("ready",   {31'b0, ready}, {31'b0, e_ready});
            chk("busy",    {31'b0, busy},  {31'b0, !e_ready});
            chk("done",    {31'b0, done},  {31'b0, e_done});
            chk("rx_data", rx_data, m_rx);

            if (!ss_n && prev_ss) begin
                last_high = highrun; recon = '0; rises = 0; lowrun = 0; falls++;
            end
            if (ss_n) highrun++; else begin highrun = 0; lowrun++; end
            if (sclk && !prev_sclk) begin recon = {recon[N-2:0], mosi}; rises++; end
            if (done) begin
                done_cnt++;
                prev_done_cyc  = last_done_cyc;
                last_done_cyc  = cyc;
                recon_at_done  = recon;
                rises_at_done  = rises;
                lowrun_at_done = lowrun;
            end
            prev_sclk = sclk;
            prev_ss   = ss_n;
        end
    end

    // miso source: 0 constant, 1 loopback, 2 mode-0 slave shifting on falling sclk
    int           miso_mode = 0;
    logic         miso_const = 0;
    logic [N-1:0] slave_word = '0;
    int           sl_idx = 0;
    logic         sl_prev_sclk = 0;

    always @(negedge clk) begin
        case (miso_mode)
            1: miso = mosi;
            2: begin
                if (ss_n === 1'b1) sl_idx = 0;
                else if (sl_prev_sclk && !sclk) sl_idx++;
                miso = (sl_idx < N) ? slave_word[N-1-sl_idx] : 1'b0;
            end
            default: miso = miso_const;
        endcase
        sl_prev_sclk = sclk;
    end

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        chk(nm, {31'b0, n < budget}, 32'd1);
    endtask

    task automatic wait_ready(input string nm, input int budget);
        int n = 0;
        while (ready !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        chk(nm, {31'b0, n < budget}, 32'd1);
    endtask

    task automatic send(input logic [N-1:0] word, output int acc);
        @(negedge clk);
        tx_data = word; start = 1; acc = cyc + 1;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        int acc, d0, f0;
        logic [N-1:0] r0;
        rst = 1; start = 0; tx_data = '0; miso = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("reset ready", {31'b0, ready}, 32'd1);
        chk("reset rx_data", rx_data, 32'h0);

        // single frame, miso held high
        miso_mode = 0; miso_const = 1;
        send(32'hA5C3_0F01, acc);
        wait_done("t2 done timeout", 400);
        wait_ready("t2 ready timeout", 20);
        chk("t2 ss_n low cycles", lowrun_at_done, 260);
        chk("t2 sclk rises", rises_at_done, 32);
        chk("t2 mosi frame", recon_at_done, 32'hA5C3_0F01);
        chk("t2 done latency", last_done_cyc - acc, 260);
        chk("t2 rx_data", rx_data, 32'hFFFF_FFFF);

        // loopback
        miso_mode = 1;
        send(32'h1234_5678, acc);
        wait_done("t3 done timeout", 400);
        wait_ready("t3 ready timeout", 20);
        chk("t3 rx_data", rx_data, 32'h1234_5678);
        repeat (20) @(negedge clk);
        chk("t3 rx_data hold", rx_data, 32'h1234_5678);

        // slave model returns DEADBEEF
        miso_mode = 2; slave_word = 32'hDEAD_BEEF;
        send(32'h0, acc);
        wait_done("t4 done timeout", 400);
        wait_ready("t4 ready timeout", 20);
        chk("t4 rx_data", rx_data, 32'hDEAD_BEEF);

        // start re-pulsed mid-frame with new tx_data
        miso_mode = 0; miso_const = 0;
        d0 = done_cnt; f0 = falls;
        send(32'h0F0F_0F0F, acc);
        repeat (D + 2 * D * 5 - 1) @(negedge clk);
        tx_data = 32'hFFFF_FFFF; start = 1;
        @(negedge clk);
        start = 0;
        wait_done("t5 done timeout", 400);
        wait_ready("t5 ready timeout", 20);
        repeat (300) @(negedge clk);
        chk("t5 mosi frame", recon_at_done, 32'h0F0F_0F0F);
        chk("t5 done count", done_cnt - d0, 1);
        chk("t5 ss_n falls", falls - f0, 1);

        // start held high: back-to-back frames
        @(negedge clk);
        tx_data = 32'h0000_0001; start = 1;
        @(negedge clk);
        tx_data = 32'h8000_0000;
        wait_done("t6 done1 timeout", 400);
        @(negedge clk);
        r0 = recon_at_done;
        wait_done("t6 done2 timeout", 400);
        start = 0;
        wait_ready("t6 ready timeout", 20);
        chk("t6 frame1 mosi", r0, 32'h0000_0001);
        chk("t6 frame2 mosi", recon_at_done, 32'h8000_0000);
        chk("t6 done spacing", last_done_cyc - prev_done_cyc, PERIOD);
        chk("t6 ss_n high gap", last_high, D);

        // reset in the middle of bit 10
        d0 = done_cnt;
        send(32'hFFFF_0000, acc);
        repeat (D + 2 * D * 10) @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        chk("t1 ss_n", {31'b0, ss_n}, 32'd1);
        chk("t1 sclk", {31'b0, sclk}, 32'd0);
        chk("t1 mosi", {31'b0, mosi}, 32'd0);
        chk("t1 ready", {31'b0, ready}, 32'd1);
        chk("t1 rx_data", rx_data, 32'h0);
        rst = 0;
        repeat (300) @(negedge clk);
        chk("t1 no done", done_cnt - d0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
